adder_rr_arbiter: RTL and testbench

- Shares one combinational 32-bit CLA adder/subtractor among NUM_REQ requesters using round-robin arbitration.
- Drives the adder operands from the granted requester, forms subtraction as A + ~B + 1, and captures the result in a one-entry response register with valid/ready back-pressure.
- Sits between the requesting units and the single shared cla_adder instance.

---
 rtl/adder_rr_arbiter.sv | 126 ++++++++++++
 tb/tb_adder_rr_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/adder_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : adder_rr_arbiter
//  Description : Round-robin arbiter sharing one combinational adder/subtractor
//                among NUM_REQ requesters, with a one-entry response register.
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int ID_W    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]       req_sub,
    output logic [WIDTH-1:0]         add_a,
    output logic [WIDTH-1:0]         add_b,
    output logic                     add_cin,
    input  logic [WIDTH-1:0]         add_s,
    input  logic                     add_cout,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic                     rsp_cout,
    output logic                     rsp_ovf
);

    localparam logic [0:0]      c_st_empty = 1'b0;
    localparam logic [0:0]      c_st_full  = 1'b1;
    localparam logic [ID_W-1:0] c_last_idx = ID_W'(NUM_REQ - 1);

    logic [0:0]       r_state;
    logic [ID_W-1:0]  r_rr_ptr;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic [ID_W-1:0]  r_id;

    logic [WIDTH-1:0] w_a   [NUM_REQ];
    logic [WIDTH-1:0] w_b   [NUM_REQ];
    logic             w_can_issue;
    logic             w_found;
    logic             w_grant;
    logic [ID_W-1:0]  w_gnt_idx;
    logic [ID_W-1:0]  w_idx;
    logic             w_ovf;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_a[gi] = req_a[gi*WIDTH +: WIDTH];
            assign w_b[gi] = req_b[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Reset blocks issue so nothing presented during reset is accepted.
    assign w_can_issue = !rst && ((r_state == c_st_empty) || rsp_ready);

    // Walk from the farthest offset down so the nearest valid one to rr_ptr wins.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        w_idx     = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_idx = ID_W'((int'(r_rr_ptr) + i) % NUM_REQ);
            if (req_valid[w_idx]) begin
                w_found   = 1'b1;
                w_gnt_idx = w_idx;
            end
        end
    end

    assign w_grant = w_can_issue && w_found;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = w_grant && (w_gnt_idx == ID_W'(i));
        end
    end

    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (w_grant) begin
            add_a   = w_a[w_gnt_idx];
            add_b   = req_sub[w_gnt_idx] ? ~w_b[w_gnt_idx] : w_b[w_gnt_idx];
            add_cin = req_sub[w_gnt_idx];
        end
    end

    assign w_ovf = (add_a[WIDTH-1] == add_b[WIDTH-1]) && (add_s[WIDTH-1] != add_a[WIDTH-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_st_empty;
            r_rr_ptr <= '0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_id     <= '0;
        end else if (w_grant) begin
            r_state  <= c_st_full;
            r_rr_ptr <= (w_gnt_idx == c_last_idx) ? '0 : w_gnt_idx + 1'b1;
            r_sum    <= add_s;
            r_cout   <= add_cout;
            r_ovf    <= w_ovf;
            r_id     <= w_gnt_idx;
        end else if (rsp_ready) begin
            r_state  <= c_st_empty;
        end
    end

    assign rsp_valid = (r_state == c_st_full);
    assign rsp_sum   = r_sum;
    assign rsp_cout  = r_cout;
    assign rsp_ovf   = r_ovf;
    assign rsp_id    = r_id;

endmodule
`default_nettype wire

// File: tb/tb_adder_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adder_rr_arbiter
//  Description : Directed self-checking bench for adder_rr_arbiter with a
//                behavioural shared adder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_rr_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 32;
    localparam int ID_W    = 2;

    logic                     clk;
    logic                     rst;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]       req_sub;
    logic [WIDTH-1:0]         add_a;
    logic [WIDTH-1:0]         add_b;
    logic                     add_cin;
    logic [WIDTH-1:0]         add_s;
    logic                     add_cout;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic [WIDTH-1:0]         rsp_sum;
    logic                     rsp_cout;
    logic                     rsp_ovf;

    int n_checks;
    int n_fail;

    adder_rr_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sub   (req_sub),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_s     (add_s),
        .add_cout  (add_cout),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_ovf   (rsp_ovf)
    );

    // Stand-in for the shared cla_adder.
    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic sub);
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
        req_sub[i]              = sub;
    endtask

    task automatic check_rsp(input string tag, input logic [ID_W-1:0] id,
                             input logic [WIDTH-1:0] sum, input logic cout, input logic ovf);
        check({tag, ".valid"}, 64'(rsp_valid), 64'(1'b1));
        check({tag, ".id"},    64'(rsp_id),    64'(id));
        check({tag, ".sum"},   64'(rsp_sum),   64'(sum));
        check({tag, ".cout"},  64'(rsp_cout),  64'(cout));
        check({tag, ".ovf"},   64'(rsp_ovf),   64'(ovf));
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_sub   = '0;
        rsp_ready = 1'b0;
        tick();
        // Request during reset must not be accepted.
        req_valid = 4'b1000;
        #1;
        check("rst.ready", 64'(req_ready), 64'h0);
        tick();
        check("rst.valid", 64'(rsp_valid), 64'h0);
        check("rst.sum",   64'(rsp_sum),   64'h0);
        check("rst.id",    64'(rsp_id),    64'h0);
        check("rst.cout",  64'(rsp_cout),  64'h0);
        check("rst.ovf",   64'(rsp_ovf),   64'h0);

        // Single add on requester 0.
        rst       = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 4'b0001;
        set_req(0, 32'h5, 32'h3, 1'b0);
        #1;
        check("add.ready", 64'(req_ready), 64'h1);
        check("add.a",     64'(add_a),     64'h5);
        check("add.b",     64'(add_b),     64'h3);
        check("add.cin",   64'(add_cin),   64'h0);
        tick();
        check_rsp("add", 2'd0, 32'h8, 1'b0, 1'b0);

        // Subtract with borrow on requester 2 (ptr now 1).
        req_valid = 4'b0100;
        set_req(2, 32'h3, 32'h5, 1'b1);
        #1;
        check("sub.ready", 64'(req_ready), 64'h4);
        check("sub.b",     64'(add_b),     64'hFFFF_FFFA);
        check("sub.cin",   64'(add_cin),   64'h1);
        tick();
        check_rsp("sub1", 2'd2, 32'hFFFF_FFFE, 1'b0, 1'b0);

        // Signed overflow on subtract, ptr now 3 so search wraps to 2.
        set_req(2, 32'h8000_0000, 32'h1, 1'b1);
        #1;
        check("sub2.ready", 64'(req_ready), 64'h4);
        tick();
        check_rsp("sub2", 2'd2, 32'h7FFF_FFFF, 1'b1, 1'b1);

        // Add overflow and add carry on requester 0.
        req_valid = 4'b0001;
        set_req(0, 32'h7FFF_FFFF, 32'h1, 1'b0);
        tick();
        check_rsp("addovf", 2'd0, 32'h8000_0000, 1'b0, 1'b1);
        set_req(0, 32'hFFFF_FFFF, 32'h1, 1'b0);
        tick();
        check_rsp("addcy", 2'd0, 32'h0, 1'b1, 1'b0);

        // Drain with no grant: valid drops, fields hold.
        req_valid = '0;
        #1;
        check("drain.adda", 64'(add_a), 64'h0);
        tick();
        check("drain.valid", 64'(rsp_valid), 64'h0);
        check("drain.sum",   64'(rsp_sum),   64'h0);
        check("drain.cout",  64'(rsp_cout),  64'h1);

        // Requester 3 alone moves ptr from 1 to 0.
        req_valid = 4'b1000;
        set_req(3, 32'h30, 32'h3, 1'b0);
        tick();
        check_rsp("r3", 2'd3, 32'h33, 1'b0, 1'b0);

        // Round robin with all requesters valid.
        for (int i = 0; i < NUM_REQ; i++) set_req(i, WIDTH'(32'h10 * i), WIDTH'(i), 1'b0);
        req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            #1;
            check($sformatf("rr%0d.ready", k), 64'(req_ready), 64'(4'b0001 << (k % 4)));
            tick();
            check_rsp($sformatf("rr%0d", k), ID_W'(k % 4), WIDTH'(32'h11 * (k % 4)), 1'b0, 1'b0);
        end

        // Back-pressure: FULL holding id 1 / 0x11, ptr 2.
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        set_req(1, 32'h100, 32'h23, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("bp%0d.ready", k), 64'(req_ready), 64'h0);
            tick();
            check_rsp($sformatf("bp%0d", k), 2'd1, 32'h11, 1'b0, 1'b0);
        end
        rsp_ready = 1'b1;
        #1;
        check("bprel.ready", 64'(req_ready), 64'h2);
        tick();
        check_rsp("bprel", 2'd1, 32'h123, 1'b0, 1'b0);

        // Reset mid-operation with FULL response and ptr 2.
        rst       = 1'b1;
        req_valid = 4'b1000;
        #1;
        check("midrst.ready", 64'(req_ready), 64'h0);
        tick();
        check("midrst.valid", 64'(rsp_valid), 64'h0);
        check("midrst.sum",   64'(rsp_sum),   64'h0);
        rst       = 1'b0;
        req_valid = 4'b1010;
        #1;
        check("postrst.ready", 64'(req_ready), 64'h2);
        tick();
        check_rsp("postrst", 2'd1, 32'h123, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
